offchip_mem_model_nch: RTL
==========================

Name: offchip_mem_model_nch

Overview:
- Parametrised multi-channel off-chip memory model that answers the HLS-generated `main` master memory bus in simulation benches.
- Generalises the fixed two-channel, byte-wide model to N channels, DW-bit data and byte-lane size masking.
- Adds programmable read and write latencies, a byte-wide preload port, sticky error flags and access counters.
- Sits between the DUT `Mout_*` outputs and `M_Rdata_ram`/`M_DataRdy`; bench ORs its outputs with the DUT `Sout_*` signals.

Parameters:
- N_CH, 2, number of independent memory channels.
- AW, 7, byte-address width per channel.
- DW, 8, data width per channel; multiple of 8, at most 64.
- MEMSIZE, 32, modelled bytes.
- BASE_ADDR, 0, first modelled byte address.
- RD_LAT, 2, read latency in cycles; at least 2.
- WR_LAT, 1, write latency in cycles; at least 1.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- Mout_oe_ram  in  N_CH  per-channel read request.
- Mout_we_ram  in  N_CH  per-channel write request.
- Mout_addr_ram  in  N_CH*AW  byte address; channel c occupies slice [c*AW +: AW].
- Mout_Wdata_ram  in  N_CH*DW  write data.
- Mout_data_ram_size  in  N_CH*SW  access size in bits; SW = clog2(DW)+1.
- init_we  in  1  preload strobe.
- init_addr  in  AW  preload byte address, absolute.
- init_data  in  8  preload byte.
- M_Rdata_ram  out  N_CH*DW  read data.
- M_DataRdy  out  N_CH  access-complete strobe.
- err_conflict  out  N_CH  sticky flag: oe and we asserted together.
- err_range  out  N_CH  sticky flag: access outside the modelled window.
- rd_count  out  32  saturating count of completed reads.
- wr_count  out  32  saturating count of completed writes.

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous and active-high.
- Reset values: M_DataRdy=0, M_Rdata_ram=0, all counters and error flags 0, per-channel latency counters 0. Memory contents are not reset.
- Size decode: nbytes = size/8. Legal sizes are 8, 16, … DW. Little-endian: byte k goes to/from addr+k, data bits [8k +: 8]. Unused upper Rdata bits read 0.
- In-range test: BASE_ADDR <= addr and addr+nbytes <= BASE_ADDR+MEMSIZE. Addition is done in AW+1 bits, so there is no wrap-around.
- Out-of-range access: no memory effect, DataRdy stays 0, err_range[c] set. The slave side answers instead.
- Conflict: oe&we on one channel means the access is ignored, err_conflict[c] set, and the latency counter is cleared.
- Master protocol: master holds oe/we, addr, data and size stable until it samples DataRdy=1.
- Read:
  - Rdata register is loaded every cycle from mem at addr, one cycle of delay.
  - cnt increments each valid cycle.
  - DataRdy = valid && cnt==RD_LAT-1, combinational on cnt; cnt returns to 0 on that cycle.
  - With RD_LAT=2: request in cycle t gives DataRdy and data in cycle t+1.
- Write:
  - DataRdy = valid && cnt==WR_LAT-1.
  - Bytes commit at the clock edge ending the DataRdy cycle.
  - With WR_LAT=1: DataRdy in the same cycle as the request.
- Request deasserted early: cnt is cleared and no DataRdy is produced.
- Same-cycle writes to the same byte: the highest channel index wins.
- Read and write to the same byte in the same cycle: the read returns the pre-write value.
- Preload: init_we writes mem[init_addr-BASE_ADDR] if it is in range. A channel write commit to the same byte wins over the preload.
- Counters: increment once per DataRdy per channel, summed across channels in a cycle; saturate at 2^32-1.
- Reset mid-access: cnt cleared with no DataRdy; the master must re-issue.

Decomposition:
- Shared package offchip_mem_pkg holds:
  - SW computation.
  - A size-to-byte-mask function.
  - The in-range function.
  - The latency-width constant clog2(max(RD_LAT,WR_LAT)).
- One natural sub-module, offchip_mem_chan_ctrl, instantiated per channel. It holds the latency counter, DataRdy generation and error flag logic.
- The top level owns the memory array, write arbitration and counters.

Test Plan:
- Preload 0xA5 at addr 3; ch0 reads addr 3, size 8, oe held -> DataRdy[0]=1 exactly 1 cycle later, Rdata[7:0]=0xA5, rd_count=1.
- DW=16: ch1 writes 0xBEEF, size 16, addr 4 -> DataRdy same cycle; a later read gives mem[4]=0xEF and mem[5]=0xBE. A size-8 write of 0x11 to addr 5 leaves mem[4]=0xEF.
- ch0 and ch1 write 0x01 and 0x02 to addr 7 in the same cycle -> mem[7]=0x02, wr_count=2.
- Read addr 32 with MEMSIZE=32 -> no DataRdy for 10 cycles, err_range[0]=1, memory unchanged.
- oe&we together on ch1 -> err_conflict[1]=1 (sticky after deassert), no DataRdy.
- RD_LAT=4: assert reset on the 2nd cycle of a read -> no DataRdy; re-issued read gives DataRdy on its 4th cycle.

Source files
------------

// File: rtl/offchip_mem_pkg.sv
// Shared helpers for the multi-channel off-chip memory model: size decode,
// byte-lane masks, window test and latency-counter sizing.
package offchip_mem_pkg;

    // Width of a per-channel size field able to hold the value DW.
    function automatic int sw_of(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // Latency counter width; must hold max(RD_LAT, WR_LAT) - 1.
    function automatic int lat_w(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Bytes moved by one access; sizes wider than the bus are clipped.
    function automatic int nbytes_of(input int size_bits, input int dw);
        int n;
        n = size_bits / 8;
        return (n > dw / 8) ? dw / 8 : n;
    endfunction

    // Little-endian lane mask: lanes 0..nbytes-1 take part in the access.
    function automatic logic [7:0] byte_mask(input int nbytes);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            m[k] = (k < nbytes);
        end
        return m;
    endfunction

    // Computed in full int width, so addr + nbytes cannot wrap.
    function automatic logic in_window(input int addr, input int nbytes,
                                       input int base, input int memsize);
        return (addr >= base) && (addr + nbytes <= base + memsize);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/offchip_mem_chan_ctrl.sv
// Per-channel control: address/size decode, latency counter, DataRdy
// generation and sticky conflict / range error flags.
module offchip_mem_chan_ctrl
    import offchip_mem_pkg::*;
#(
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int MEMSIZE   = 32,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   oe,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [sw_of(DW)-1:0]   size,
    output logic                   data_rdy,
    output logic                   in_range,
    output logic [DW/8-1:0]        mask,
    output logic                   err_conflict,
    output logic                   err_range
);

    localparam int NB = DW / 8;
    localparam int LW = lat_w(RD_LAT, WR_LAT);

    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_next;
    logic [7:0]    full_mask;
    logic          valid_rd;
    logic          valid_wr;
    int            nbytes;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nbytes    = nbytes_of(int'(size), DW);
        full_mask = byte_mask(nbytes);
        mask      = full_mask[NB-1:0];
        in_range  = in_window(int'(addr), nbytes, BASE_ADDR, MEMSIZE);
        valid_rd  = oe && !we && in_range;
        valid_wr  = we && !oe && in_range;

        // Reset masks the strobe so an access caught by reset never completes.
        data_rdy  = !reset && ((valid_rd && cnt == LW'(RD_LAT - 1)) ||
                               (valid_wr && cnt == LW'(WR_LAT - 1)));

        cnt_next  = '0;
        if ((valid_rd || valid_wr) && !data_rdy) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            err_conflict <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (oe && we) begin
                err_conflict <= 1'b1;
            end
            if ((oe || we) && !in_range) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/offchip_mem_model_nch.sv
// N-channel off-chip memory model answering the HLS `main` master bus:
// shared byte array, per-channel latency control, preload port and counters.
module offchip_mem_model_nch
    import offchip_mem_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int MEMSIZE   = 32,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_CH-1:0]             Mout_oe_ram,
    input  logic [N_CH-1:0]             Mout_we_ram,
    input  logic [N_CH*AW-1:0]          Mout_addr_ram,
    input  logic [N_CH*DW-1:0]          Mout_Wdata_ram,
    input  logic [N_CH*sw_of(DW)-1:0]   Mout_data_ram_size,
    input  logic                        init_we,
    input  logic [AW-1:0]               init_addr,
    input  logic [7:0]                  init_data,
    output logic [N_CH*DW-1:0]          M_Rdata_ram,
    output logic [N_CH-1:0]             M_DataRdy,
    output logic [N_CH-1:0]             err_conflict,
    output logic [N_CH-1:0]             err_range,
    output logic [31:0]                 rd_count,
    output logic [31:0]                 wr_count
);

    localparam int SW = sw_of(DW);
    localparam int NB = DW / 8;
    localparam int MW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [7:0]      mem [MEMSIZE];
    logic [N_CH-1:0] rdy;
    logic [N_CH-1:0] in_rng;
    logic [NB-1:0]   mask     [N_CH];
    logic [NB-1:0]   wr_en    [N_CH];
    logic [MW-1:0]   byte_idx [N_CH][NB];
    logic [N_CH*DW-1:0] rd_next;
    logic            init_ok;
    logic [MW-1:0]   init_idx;
    logic [31:0]     rd_inc;
    logic [31:0]     wr_inc;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        offchip_mem_chan_ctrl #(
            .AW        (AW),
            .DW        (DW),
            .MEMSIZE   (MEMSIZE),
            .BASE_ADDR (BASE_ADDR),
            .RD_LAT    (RD_LAT),
            .WR_LAT    (WR_LAT)
        ) u_ctrl (
            .clock        (clock),
            .reset        (reset),
            .oe           (Mout_oe_ram[c]),
            .we           (Mout_we_ram[c]),
            .addr         (Mout_addr_ram[c*AW +: AW]),
            .size         (Mout_data_ram_size[c*SW +: SW]),
            .data_rdy     (rdy[c]),
            .in_range     (in_rng[c]),
            .mask         (mask[c]),
            .err_conflict (err_conflict[c]),
            .err_range    (err_range[c])
        );
    end

    assign M_DataRdy = rdy;

    always_comb begin
        init_ok  = in_window(int'(init_addr), 1, BASE_ADDR, MEMSIZE);
        init_idx = MW'(int'(init_addr) - BASE_ADDR);
        rd_next  = '0;
        rd_inc   = '0;
        wr_inc   = '0;
        for (int c = 0; c < N_CH; c++) begin
            rd_inc = rd_inc + 32'(rdy[c] & Mout_oe_ram[c]);
            wr_inc = wr_inc + 32'(rdy[c] & Mout_we_ram[c]);
            for (int k = 0; k < NB; k++) begin
                byte_idx[c][k] = MW'(int'(Mout_addr_ram[c*AW +: AW]) - BASE_ADDR + k);
                wr_en[c][k]    = rdy[c] && Mout_we_ram[c] && mask[c][k];
                if (in_rng[c] && mask[c][k]) begin
                    rd_next[c*DW + 8*k +: 8] = mem[byte_idx[c][k]];
                end
            end
        end
    end

    // NOTE: the array has no reset; contents persist across reset exactly
    // like the external memory it models.
    // Later writers in this block override earlier ones: preload first, then
    // channels in ascending order so the highest index wins a shared byte.
    always_ff @(posedge clock) begin
        if (init_we && init_ok) begin
            mem[init_idx] <= init_data;
        end
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_en[c][k]) begin
                    mem[byte_idx[c][k]] <= Mout_Wdata_ram[c*DW + 8*k +: 8];
                end
            end
        end
    end

    // Read data is captured every cycle; a same-cycle write is not visible yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            M_Rdata_ram <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            M_Rdata_ram <= rd_next;
            rd_count    <= sat_add(rd_count, rd_inc);
            wr_count    <= sat_add(wr_count, wr_inc);
        end
    end

endmodule
